// File: rtl/key_entry_controller.sv
// Keypad entry controller: takes digit/operator/equal events from the keypad
// scanner, builds two signed BCD operands and an operator code, requests a
// computation and holds the returned result for the display.
module key_entry_controller #(
  parameter int MAX_DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      nRST,
  input  logic                      read_input,
  input  logic [3:0]                keypad_input,
  input  logic [2:0]                operator_input,
  input  logic                      equal_input,
  output logic                      key_read,
  output logic [4*MAX_DIGITS-1:0]   operand_a,
  output logic [4*MAX_DIGITS-1:0]   operand_b,
  output logic                      neg_a,
  output logic                      neg_b,
  output logic [2:0]                op_code,
  output logic                      calc_req,
  input  logic                      calc_ack,
  input  logic [4*MAX_DIGITS-1:0]   result_bcd,
  input  logic                      result_neg,
  input  logic                      result_err,
  output logic [4*MAX_DIGITS-1:0]   display_bcd,
  output logic                      display_neg,
  output logic                      display_err,
  output logic [1:0]                entry_state
);

  // state    | meaning
  // ENTER_A  | collecting operand A digits / sign, waiting for an operator
  // ENTER_B  | collecting operand B digits / sign, waiting for equal
  // REQUEST  | calc_req held high until the arithmetic unit acknowledges
  // RESULT   | showing the latched result; next key starts or chains entry

  localparam int W  = 4 * MAX_DIGITS;
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    REQUEST = 2'd2,
    RESULT  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            armed_q, armed_d;
  logic            key_read_q, key_read_d;
  logic [W-1:0]    opa_q, opa_d, opb_q, opb_d;
  logic            neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [CW-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [2:0]      op_q, op_d;
  logic [W-1:0]    res_q, res_d;
  logic            res_neg_q, res_neg_d, res_err_q, res_err_d;
  logic [W-1:0]    disp_q, disp_d;
  logic            disp_neg_q, disp_neg_d, disp_err_q, disp_err_d;

  logic idle, evt, is_eq, is_op, is_dig, is_sign, is_arith;

  // Event detection, decode and the entry FSM next-state / datapath logic.
  always_comb begin
    state_d    = state_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    neg_a_d    = neg_a_q;
    neg_b_d    = neg_b_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;
    op_d       = op_q;
    res_d      = res_q;
    res_neg_d  = res_neg_q;
    res_err_d  = res_err_q;

    idle     = !read_input && (operator_input == 3'b000) && !equal_input;
    evt      = armed_q && !idle;
    // Priority equal > operator > digit; only one decode fires per event.
    is_eq    = evt && equal_input;
    is_op    = evt && !equal_input && (operator_input != 3'b000);
    is_dig   = evt && !equal_input && (operator_input == 3'b000) && read_input;
    is_sign  = is_op && (operator_input == 3'b001);
    is_arith = is_op && (operator_input inside {3'b010, 3'b011, 3'b100});

    key_read_d = evt;
    armed_d    = armed_q;
    if (evt)  armed_d = 1'b0;
    if (idle) armed_d = 1'b1;

    case (state_q)
      ENTER_A: begin
        if (is_dig && cnt_a_q != CNT_MAX) begin
          opa_d   = {opa_q[W-5:0], keypad_input};
          cnt_a_d = cnt_a_q + CW'(1);
        end else if (is_sign && cnt_a_q == '0) begin
          neg_a_d = !neg_a_q;
        end else if (is_arith) begin
          op_d    = operator_input;
          state_d = ENTER_B;
        end
      end
      ENTER_B: begin
        if (is_eq) begin
          state_d = REQUEST;
        end else if (is_dig && cnt_b_q != CNT_MAX) begin
          opb_d   = {opb_q[W-5:0], keypad_input};
          cnt_b_d = cnt_b_q + CW'(1);
        end else if (is_sign && cnt_b_q == '0) begin
          neg_b_d = !neg_b_q;
        end else if (is_arith && cnt_b_q == '0) begin
          op_d = operator_input;
        end
      end
      REQUEST: begin
        // Key events here are acknowledged but otherwise dropped.
        if (calc_ack) begin
          res_d     = result_bcd;
          res_neg_d = result_neg;
          res_err_d = result_err;
          state_d   = RESULT;
        end
      end
      RESULT: begin
        if (is_dig || is_sign || (is_arith && res_err_q)) begin
          opa_d   = '0;
          opb_d   = '0;
          neg_a_d = 1'b0;
          neg_b_d = 1'b0;
          cnt_a_d = '0;
          cnt_b_d = '0;
          op_d    = 3'b000;
          state_d = ENTER_A;
          if (is_dig) begin
            opa_d   = {{(W-4){1'b0}}, keypad_input};
            cnt_a_d = CW'(1);
          end
          if (is_sign) neg_a_d = 1'b1;
        end else if (is_arith) begin
          // Chain: the result becomes a full-length operand A so no more
          // digits can be appended to it.
          opa_d   = res_q;
          neg_a_d = res_neg_q;
          cnt_a_d = CNT_MAX;
          opb_d   = '0;
          neg_b_d = 1'b0;
          cnt_b_d = '0;
          op_d    = operator_input;
          state_d = ENTER_B;
        end
      end
      default: state_d = ENTER_A;
    endcase
  end

  // Display source selection; registered so it trails register changes by one cycle.
  always_comb begin
    disp_d     = opa_q;
    disp_neg_d = neg_a_q;
    disp_err_d = 1'b0;
    case (state_q)
      ENTER_B: begin
        if (cnt_b_q != '0) begin
          disp_d     = opb_q;
          disp_neg_d = neg_b_q;
        end
      end
      REQUEST: begin
        disp_d     = opb_q;
        disp_neg_d = neg_b_q;
      end
      RESULT: begin
        disp_d     = res_q;
        disp_neg_d = res_neg_q;
        disp_err_d = res_err_q;
      end
      default: ;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q    <= ENTER_A;
      armed_q    <= 1'b1;
      key_read_q <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      op_q       <= 3'b000;
      res_q      <= '0;
      res_neg_q  <= 1'b0;
      res_err_q  <= 1'b0;
      disp_q     <= '0;
      disp_neg_q <= 1'b0;
      disp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      key_read_q <= key_read_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      neg_a_q    <= neg_a_d;
      neg_b_q    <= neg_b_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      op_q       <= op_d;
      res_q      <= res_d;
      res_neg_q  <= res_neg_d;
      res_err_q  <= res_err_d;
      disp_q     <= disp_d;
      disp_neg_q <= disp_neg_d;
      disp_err_q <= disp_err_d;
    end
  end

  // calc_req decodes the state register so reset removes it immediately.
  assign calc_req    = (state_q == REQUEST);
  assign key_read    = key_read_q;
  assign operand_a   = opa_q;
  assign operand_b   = opb_q;
  assign neg_a       = neg_a_q;
  assign neg_b       = neg_b_q;
  assign op_code     = op_q;
  assign display_bcd = disp_q;
  assign display_neg = disp_neg_q;
  assign display_err = disp_err_q;
  assign entry_state = state_q;

endmodule

// File: tb/tb_key_entry_controller.sv
// Bench for key_entry_controller: table of key events with expected register
// state, a key_read-driven scoreboard, and hand sequences for the handshake
// with the arithmetic unit and reset corners.
module tb_key_entry_controller;

  localparam int MAX_DIGITS = 4;
  localparam int W = 16;
  localparam int K_DIG = 0;
  localparam int K_OP  = 1;
  localparam int K_EQ  = 2;

  logic         clk = 1'b0;
  logic         nRST = 1'b0;
  logic         read_input = 1'b0;
  logic [3:0]   keypad_input = '0;
  logic [2:0]   operator_input = '0;
  logic         equal_input = 1'b0;
  logic         key_read;
  logic [W-1:0] operand_a, operand_b;
  logic         neg_a, neg_b;
  logic [2:0]   op_code;
  logic         calc_req;
  logic         calc_ack = 1'b0;
  logic [W-1:0] result_bcd = '0;
  logic         result_neg = 1'b0;
  logic         result_err = 1'b0;
  logic [W-1:0] display_bcd;
  logic         display_neg, display_err;
  logic [1:0]   entry_state;

  key_entry_controller #(.MAX_DIGITS(MAX_DIGITS)) dut (
    .clk(clk), .nRST(nRST), .read_input(read_input), .keypad_input(keypad_input),
    .operator_input(operator_input), .equal_input(equal_input), .key_read(key_read),
    .operand_a(operand_a), .operand_b(operand_b), .neg_a(neg_a), .neg_b(neg_b),
    .op_code(op_code), .calc_req(calc_req), .calc_ack(calc_ack),
    .result_bcd(result_bcd), .result_neg(result_neg), .result_err(result_err),
    .display_bcd(display_bcd), .display_neg(display_neg), .display_err(display_err),
    .entry_state(entry_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          grp;
    int          kind;
    logic [3:0]  val;
    logic [15:0] a;
    logic [15:0] b;
    logic        na;
    logic        nb;
    logic [2:0]  op;
    logic [1:0]  st;
    logic [15:0] disp;
    logic        dneg;
  } vec_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        na;
    logic        nb;
    logic [2:0]  op;
    logic [1:0]  st;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;

  // Scoreboard: every key_read pulse consumes one expected post-event snapshot.
  always @(negedge clk) begin
    exp_t e;
    if (nRST && key_read) begin
      pulses++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL key_read_unexpected: actual pulse at %0t, required none", $time);
      end else begin
        e = sb_q.pop_front();
        if ({operand_a, operand_b, neg_a, neg_b, op_code, entry_state} !==
            {e.a, e.b, e.na, e.nb, e.op, e.st}) begin
          errors++;
          $display("FAIL key_event_state: actual a=%h b=%h na=%b nb=%b op=%b st=%0d required a=%h b=%h na=%b nb=%b op=%b st=%0d",
                   operand_a, operand_b, neg_a, neg_b, op_code, entry_state,
                   e.a, e.b, e.na, e.nb, e.op, e.st);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic add(input int grp, input int kind, input logic [3:0] val,
                     input logic [15:0] a, input logic [15:0] b, input logic na,
                     input logic nb, input logic [2:0] op, input logic [1:0] st,
                     input logic [15:0] disp, input logic dneg);
    vec_t v;
    v.grp = grp; v.kind = kind; v.val = val; v.a = a; v.b = b; v.na = na; v.nb = nb;
    v.op = op; v.st = st; v.disp = disp; v.dneg = dneg;
    vecs.push_back(v);
  endtask

  task automatic press(input int kind, input logic [3:0] val);
    @(negedge clk);
    case (kind)
      K_DIG:   begin read_input = 1'b1; keypad_input = val; end
      K_OP:    operator_input = val[2:0];
      default: equal_input = 1'b1;
    endcase
    @(negedge clk);
    read_input = 1'b0; keypad_input = '0; operator_input = '0; equal_input = 1'b0;
  endtask

  task automatic run_group(input int grp);
    exp_t e;
    foreach (vecs[i]) begin
      if (vecs[i].grp == grp) begin
        e.a = vecs[i].a; e.b = vecs[i].b; e.na = vecs[i].na; e.nb = vecs[i].nb;
        e.op = vecs[i].op; e.st = vecs[i].st;
        sb_q.push_back(e);
        press(vecs[i].kind, vecs[i].val);
        @(negedge clk);
        chk($sformatf("display_g%0d_v%0d", grp, i), {15'd0, display_neg, display_bcd},
            {15'd0, vecs[i].dneg, vecs[i].disp});
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    nRST = 1'b0;
    repeat (2) @(negedge clk);
    nRST = 1'b1;
  endtask

  task automatic do_ack(input string name, input logic [15:0] r, input logic rn, input logic re,
                        input logic in_request);
    @(negedge clk);
    calc_ack = 1'b1; result_bcd = r; result_neg = rn; result_err = re;
    #1;
    if (in_request) chk({name, "_req_ack_cycle"}, {31'd0, calc_req}, 32'd1);
    @(negedge clk);
    calc_ack = 1'b0; result_bcd = '0; result_neg = 1'b0; result_err = 1'b0;
    if (in_request) begin
      chk({name, "_state"}, {30'd0, entry_state}, 32'd3);
      chk({name, "_req_drop"}, {31'd0, calc_req}, 32'd0);
      @(negedge clk);
      chk({name, "_display"}, {14'd0, display_err, display_neg, display_bcd},
          {14'd0, re, rn, r});
    end
  endtask

  initial begin
    int p0;
    //   grp kind   val  a        b        na nb op      st disp     dneg
    // Basic entry 12 + 7
    add(1, K_DIG, 1, 16'h0001, 16'h0000, 0, 0, 3'b000, 0, 16'h0001, 0);
    add(1, K_DIG, 2, 16'h0012, 16'h0000, 0, 0, 3'b000, 0, 16'h0012, 0);
    add(1, K_OP,  2, 16'h0012, 16'h0000, 0, 0, 3'b010, 1, 16'h0012, 0);
    add(1, K_DIG, 7, 16'h0012, 16'h0007, 0, 0, 3'b010, 1, 16'h0007, 0);
    add(1, K_EQ,  0, 16'h0012, 16'h0007, 0, 0, 3'b010, 2, 16'h0007, 0);
    // Chain the result with multiply
    add(2, K_OP,  4, 16'h0019, 16'h0000, 0, 0, 3'b100, 1, 16'h0019, 0);
    add(2, K_DIG, 3, 16'h0019, 16'h0003, 0, 0, 3'b100, 1, 16'h0003, 0);
    add(2, K_EQ,  0, 16'h0019, 16'h0003, 0, 0, 3'b100, 2, 16'h0003, 0);
    // Operator after an error result clears everything
    add(3, K_OP,  2, 16'h0000, 16'h0000, 0, 0, 3'b000, 0, 16'h0000, 0);
    // Digit limit
    add(4, K_DIG, 1, 16'h0001, 16'h0000, 0, 0, 3'b000, 0, 16'h0001, 0);
    add(4, K_DIG, 2, 16'h0012, 16'h0000, 0, 0, 3'b000, 0, 16'h0012, 0);
    add(4, K_DIG, 3, 16'h0123, 16'h0000, 0, 0, 3'b000, 0, 16'h0123, 0);
    add(4, K_DIG, 4, 16'h1234, 16'h0000, 0, 0, 3'b000, 0, 16'h1234, 0);
    add(4, K_DIG, 5, 16'h1234, 16'h0000, 0, 0, 3'b000, 0, 16'h1234, 0);
    // Signs: -3 - -2
    add(5, K_OP,  1, 16'h0000, 16'h0000, 1, 0, 3'b000, 0, 16'h0000, 1);
    add(5, K_DIG, 3, 16'h0003, 16'h0000, 1, 0, 3'b000, 0, 16'h0003, 1);
    add(5, K_OP,  1, 16'h0003, 16'h0000, 1, 0, 3'b000, 0, 16'h0003, 1);
    add(5, K_OP,  3, 16'h0003, 16'h0000, 1, 0, 3'b011, 1, 16'h0003, 1);
    add(5, K_OP,  1, 16'h0003, 16'h0000, 1, 1, 3'b011, 1, 16'h0003, 1);
    add(5, K_DIG, 2, 16'h0003, 16'h0002, 1, 1, 3'b011, 1, 16'h0002, 1);
    add(5, K_EQ,  0, 16'h0003, 16'h0002, 1, 1, 3'b011, 2, 16'h0002, 1);
    // Digit from RESULT starts a fresh entry
    add(6, K_DIG, 5, 16'h0005, 16'h0000, 0, 0, 3'b000, 0, 16'h0005, 0);
    // After held operator: replace op while B empty, then op ignored once B has digits
    add(7, K_OP,  3, 16'h0000, 16'h0000, 0, 0, 3'b011, 1, 16'h0000, 0);
    add(7, K_DIG, 4, 16'h0000, 16'h0004, 0, 0, 3'b011, 1, 16'h0004, 0);
    add(7, K_OP,  4, 16'h0000, 16'h0004, 0, 0, 3'b011, 1, 16'h0004, 0);
    add(8, K_EQ,  0, 16'h0000, 16'h0004, 0, 0, 3'b011, 2, 16'h0004, 0);
    // Digit in REQUEST is acknowledged but discarded
    add(9, K_DIG, 9, 16'h0000, 16'h0004, 0, 0, 3'b011, 2, 16'h0004, 0);

    repeat (2) @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);
    chk("reset_state", {30'd0, entry_state}, 32'd0);
    chk("reset_outputs", {operand_a, operand_b}, 32'd0);
    chk("reset_flags", {24'd0, key_read, calc_req, neg_a, neg_b, op_code, display_err},
        32'd0);
    chk("reset_display", {15'd0, display_neg, display_bcd}, 32'd0);

    run_group(1);
    chk("t1_calc_req", {31'd0, calc_req}, 32'd1);
    do_ack("t1_ack", 16'h0019, 1'b0, 1'b0, 1'b1);

    run_group(2);
    do_ack("t5_err_ack", 16'h0000, 1'b0, 1'b1, 1'b1);
    run_group(3);
    chk("t5_err_cleared", {31'd0, display_err}, 32'd0);

    run_group(4);

    do_reset();
    run_group(5);
    do_ack("t4_ack", 16'h0042, 1'b1, 1'b0, 1'b1);
    run_group(6);

    do_reset();
    // Held operator level: one acknowledge only
    begin
      exp_t e;
      e.a = 16'h0000; e.b = 16'h0000; e.na = 1'b0; e.nb = 1'b0; e.op = 3'b010; e.st = 2'd1;
      sb_q.push_back(e);
    end
    p0 = pulses;
    @(negedge clk);
    operator_input = 3'b010;
    repeat (10) @(negedge clk);
    operator_input = 3'b000;
    @(negedge clk);
    chk("t3_held_pulses", pulses - p0, 32'd1);
    run_group(7);

    // calc_ack outside REQUEST must be ignored
    do_ack("stray_ack", 16'h0999, 1'b1, 1'b1, 1'b0);
    chk("stray_ack_state", {30'd0, entry_state}, 32'd1);
    @(negedge clk);
    chk("stray_ack_display", {14'd0, display_err, display_neg, display_bcd},
        {14'd0, 1'b0, 1'b0, 16'h0004});

    run_group(8);
    chk("t6_calc_req", {31'd0, calc_req}, 32'd1);
    run_group(9);

    // Asynchronous reset in REQUEST
    @(negedge clk);
    #2 nRST = 1'b0;
    #1;
    chk("t6_rst_calc_req", {31'd0, calc_req}, 32'd0);
    chk("t6_rst_state", {30'd0, entry_state}, 32'd0);
    chk("t6_rst_operands", {operand_a, operand_b}, 32'd0);
    chk("t6_rst_flags", {24'd0, key_read, neg_a, neg_b, op_code, display_err, display_neg},
        32'd0);
    chk("t6_rst_display", {16'd0, display_bcd}, 32'd0);
    @(negedge clk);
    nRST = 1'b1;
    repeat (2) @(negedge clk);

    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_entry_controller.md
Name: key_entry_controller

Overview:
Consumer side of the keypad scanner handshake. It accepts digit, operator and equal events and acknowledges each with key_read. It assembles two signed BCD operands plus an operator code, then issues a compute request to the arithmetic unit. It latches the returned result and drives the display-facing BCD value.

Parameters:
MAX_DIGITS, 4, BCD digits per operand; operand and result width is 4*MAX_DIGITS (W).

Ports:
clk  input  1  system clock
nRST  input  1  asynchronous active-low reset
read_input  input  1  one-cycle digit-event pulse from the scanner
keypad_input  input  4  digit value 0-9; valid in the read_input cycle
operator_input  input  3  level: 001 minus sign, 010 add, 011 sub, 100 mul, 000 none
equal_input  input  1  level: equal key held in confirm
key_read  output  1  one-cycle acknowledge to the scanner
operand_a  output  W  BCD operand A, digit 0 in [3:0]
operand_b  output  W  BCD operand B
neg_a, neg_b  output  1 each  operand sign flags
op_code  output  3  latched operator (010/011/100)
calc_req  output  1  compute request, level
calc_ack  input  1  arithmetic unit done, one-cycle pulse
result_bcd  input  W  result; sampled on calc_ack
result_neg, result_err  input  1 each  sampled on calc_ack
display_bcd  output  W  value to show
display_neg, display_err  output  1 each  sign and error flags for the display
entry_state  output  2  current FSM state, for debug

Behaviour:
- Clocking and reset: one clock domain (clk). Asynchronous active-low reset nRST. On reset, every output and register is 0, state is ENTER_A and armed is 1.
- Event detect: evt = armed & (read_input | operator_input!=0 | equal_input).
  - On evt, key_read is 1 on the next cycle only, and armed is cleared.
  - armed is set again in any cycle where read_input=0, operator_input=0 and equal_input=0.
  - key_read is asserted in every state, including REQUEST; events in REQUEST are discarded.
- Event decode: the event is decoded in the evt cycle with priority equal > operator > digit.
- Digit entry: operand <= {operand[W-5:0], keypad_input}; digit count +1. At count==MAX_DIGITS, further digits are ignored and the operand is held.
- ENTER_A (0):
  - digit: shift into operand_a.
  - 001: toggle neg_a only if count_a==0, else ignore.
  - 010/011/100: op_code <= code; go to ENTER_B.
  - equal: ignore.
- ENTER_B (1):
  - digit: shift into operand_b.
  - 001: toggle neg_b if count_b==0, else ignore.
  - arithmetic op: if count_b==0, replace op_code; else ignore.
  - equal: go to REQUEST.
- REQUEST (2): calc_req=1 from state entry until the calc_ack cycle inclusive; it falls the cycle after. On calc_ack, latch result_bcd/neg/err into the result registers and go to RESULT. A calc_ack seen outside REQUEST is ignored.
- RESULT (3):
  - digit: clear both operands, signs, counts and op_code; operand_a <= digit, count_a=1; go to ENTER_A.
  - 001: clear all, neg_a=1; go to ENTER_A.
  - arithmetic op with result_err=0: operand_a <= result, neg_a <= result_neg, count_a=MAX_DIGITS, operand_b=0, neg_b=0, count_b=0, op_code <= code; go to ENTER_B.
  - arithmetic op with result_err=1: clear all; go to ENTER_A.
  - equal: ignore.
- Display (registered, updated the cycle after any change):
  - ENTER_A: operand_a/neg_a.
  - ENTER_B: operand_b/neg_b if count_b>0, else operand_a/neg_a.
  - REQUEST: operand_b/neg_b.
  - RESULT: result/neg/err.
  - display_err is 0 outside RESULT.
- Reset mid-REQUEST: calc_req drops immediately (asynchronously) and the state returns to ENTER_A.

Test Plan:
1. Reset, then digits 1,2, op 010, digit 7, equal -> operand_a=0x0012, op_code=010, operand_b=0x0007, calc_req=1; calc_ack with result 0x0019 -> display_bcd=0x0019, calc_req=0 the next cycle.
2. Five digits 1,2,3,4,5 in ENTER_A -> operand_a=0x1234; the fifth key still gets a key_read pulse.
3. Operator level held for 10 cycles -> exactly one key_read pulse; no second pulse until operator_input returns to 000 and is pressed again.
4. 001 then 3, 011, 001, 2, equal -> neg_a=1, operand_a=0x0003, op_code=011, neg_b=1, operand_b=0x0002.
5. Chaining: in RESULT with 0x0019, press 100 -> operand_a=0x0019, state ENTER_B. With result_err=1, pressing 010 clears everything and returns to ENTER_A.
6. Digit pressed in REQUEST -> key_read pulses and operand_b is unchanged; nRST asserted mid-REQUEST -> calc_req=0 and all outputs 0 at once.
